// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's control/status and gate-facing signals.
//   master : controller side (drives start/abort and the gate's output back in)
//   slave  : sweeper side (drives gate stimulus and sweep status/results)
// Signals:
//   start, abort        sweep request / cancel
//   dut_in, dut_out     gate stimulus and gate output
//   busy, done          sweep in progress / one-cycle completion pulse
//   signature           captured truth table, row v in bit (2**N_IN-1-v)
//   match, first_fail   comparison result against the expected code
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 abort;
   logic [N_IN-1:0]      dut_in;
   logic                 dut_out;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   signature;
   logic                 match;
   logic [N_IN-1:0]      first_fail;

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, signature, match, first_fail
   );

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, signature, match, first_fail
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a combinational gate through every input
// combination in ascending order, holds each vector SETTLE cycles, samples
// the gate output on the last held cycle and assembles a signature, then
// compares it against EXPECT and reports the lowest failing row.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (highest priority)
//   bus    truth_table_sweeper_if.slave (start, abort, dut_in, dut_out,
//          busy, done, signature, match, first_fail)
module truth_table_sweeper #(
   parameter int                 N_IN   = 3,
   parameter int                 SETTLE = 4,
   parameter logic [2**N_IN-1:0] EXPECT = 8'hC2
) (
   input  logic                   clk,
   input  logic                   reset,
   truth_table_sweeper_if.slave   bus
);
   localparam int              W        = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_ROW = '1;
   localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

   state_t            state;
   logic [7:0]        count;
   logic [N_IN-1:0]   v;
   logic [N_IN-1:0]   dut_in_r;
   logic              busy_r;
   logic              done_r;
   logic [W-1:0]      signature_r;
   logic              match_r;
   logic [N_IN-1:0]   first_fail_r;
   logic              fail_seen;

   // Row v maps to bit W-1-v, which for an N_IN-bit index is simply ~v.
   logic [N_IN-1:0]   bitpos;
   logic              sample;
   logic              mism;
   logic [W-1:0]      sig_next;

   always_comb begin
      bitpos           = ~v;
      sample           = (count == CNT_LAST);
      mism             = (bus.dut_out != EXPECT[bitpos]);
      sig_next         = signature_r;
      sig_next[bitpos] = bus.dut_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         v            <= '0;
         dut_in_r     <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         signature_r  <= '0;
         match_r      <= 1'b0;
         first_fail_r <= '0;
         fail_seen    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  state        <= APPLY;
                  busy_r       <= 1'b1;
                  dut_in_r     <= '0;
                  v            <= '0;
                  count        <= '0;
                  signature_r  <= '0;
                  match_r      <= 1'b0;
                  first_fail_r <= '0;
                  fail_seen    <= 1'b0;
               end
            end

            APPLY: begin
               if (bus.abort) begin
                  state        <= IDLE;
                  busy_r       <= 1'b0;
                  dut_in_r     <= '0;
                  v            <= '0;
                  count        <= '0;
                  signature_r  <= '0;
                  match_r      <= 1'b0;
                  first_fail_r <= '0;
                  fail_seen    <= 1'b0;
               end else if (sample) begin
                  signature_r <= sig_next;
                  count       <= '0;
                  // Only the first (lowest-row) mismatch is recorded.
                  if (mism && !fail_seen) begin
                     first_fail_r <= v;
                     fail_seen    <= 1'b1;
                  end
                  if (v == LAST_ROW) begin
                     // Result is registered here so it lines up with done.
                     state    <= FINISH;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     dut_in_r <= '0;
                     match_r  <= (sig_next == EXPECT);
                  end else begin
                     v        <= v + 1'b1;
                     dut_in_r <= v + 1'b1;
                  end
               end else begin
                  count <= count + 8'd1;
               end
            end

            FINISH: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dut_in     = dut_in_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.signature  = signature_r;
   assign bus.match      = match_r;
   assign bus.first_fail = first_fail_r;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper. Three instances: SETTLE=4 with a
// selectable combinational gate model, and SETTLE=1 / SETTLE=2 each driving a
// gate model with one register of delay. Expected results are queued when a
// sweep is started; per-instance monitors pop and compare on every done.
module tb_truth_table_sweeper;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int          checks = 0;
   int          passes = 0;
   int          m4 = 0;   // 0 correct, 1 inverted, 2 row5 stuck-at-1

   typedef struct {
      int unsigned cyc;
      logic [7:0]  sig;
      logic        match;
      logic [2:0]  ff;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t e4, e1, e2;

   truth_table_sweeper_if #(.N_IN(3)) if4();
   truth_table_sweeper_if #(.N_IN(3)) if1();
   truth_table_sweeper_if #(.N_IN(3)) if2();

   truth_table_sweeper #(.N_IN(3), .SETTLE(4), .EXPECT(8'hC2)) u4 (.clk(clk), .reset(reset), .bus(if4));
   truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECT(8'hC2)) u1 (.clk(clk), .reset(reset), .bus(if1));
   truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECT(8'hC2)) u2 (.clk(clk), .reset(reset), .bus(if2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference gate 0xC2: row 0 is the MSB.
   function automatic logic gate_c2(input logic [2:0] x);
      logic [7:0] tt;
      logic [2:0] idx;
      tt  = 8'hC2;
      idx = 3'd7 - x;
      return tt[idx];
   endfunction

   always_comb begin
      case (m4)
         1:       if4.dut_out = ~gate_c2(if4.dut_in);
         2:       if4.dut_out = (if4.dut_in == 3'd5) ? 1'b1 : gate_c2(if4.dut_in);
         default: if4.dut_out = gate_c2(if4.dut_in);
      endcase
   end

   logic r1, r2;
   always @(posedge clk) begin
      r1 <= gate_c2(if1.dut_in);
      r2 <= gate_c2(if2.dut_in);
   end
   assign if1.dut_out = r1;
   assign if2.dut_out = r2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitors
   always @(negedge clk) begin
      if (!reset && if4.done === 1'b1) begin
         if (q4.size() == 0) chk("u4_spurious_done", 32'(if4.done), 32'd0);
         else begin
            e4 = q4.pop_front();
            chk("u4_done_cycle", cyc, e4.cyc);
            chk("u4_signature", 32'(if4.signature), 32'(e4.sig));
            chk("u4_match", 32'(if4.match), 32'(e4.match));
            chk("u4_first_fail", 32'(if4.first_fail), 32'(e4.ff));
            chk("u4_busy_at_done", 32'(if4.busy), 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && if1.done === 1'b1) begin
         if (q1.size() == 0) chk("u1_spurious_done", 32'(if1.done), 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("u1_done_cycle", cyc, e1.cyc);
            chk("u1_signature", 32'(if1.signature), 32'(e1.sig));
            chk("u1_match", 32'(if1.match), 32'(e1.match));
            chk("u1_first_fail", 32'(if1.first_fail), 32'(e1.ff));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && if2.done === 1'b1) begin
         if (q2.size() == 0) chk("u2_spurious_done", 32'(if2.done), 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("u2_done_cycle", cyc, e2.cyc);
            chk("u2_signature", 32'(if2.signature), 32'(e2.sig));
            chk("u2_match", 32'(if2.match), 32'(e2.match));
            chk("u2_first_fail", 32'(if2.first_fail), 32'(e2.ff));
         end
      end
   end

   // Stimulus helpers: all start and end on a falling edge.
   task automatic kick(input int which, output int unsigned t);
      t = cyc;
      case (which)
         1:       if1.start = 1'b1;
         2:       if2.start = 1'b1;
         default: if4.start = 1'b1;
      endcase
      @(negedge clk);
      if1.start = 1'b0;
      if2.start = 1'b0;
      if4.start = 1'b0;
   endtask

   task automatic wait_empty(input int which, input int budget);
      int unsigned sz;
      for (int i = 0; i < budget; i++) begin
         sz = (which == 1) ? q1.size() : (which == 2) ? q2.size() : q4.size();
         if (sz == 0) break;
         @(negedge clk);
      end
      sz = (which == 1) ? q1.size() : (which == 2) ? q2.size() : q4.size();
      chk("sweep_timeout_pending", sz, 32'd0);
   endtask

   task automatic chk_u4_zero(input string tag);
      chk({tag, "_busy"}, 32'(if4.busy), 32'd0);
      chk({tag, "_done"}, 32'(if4.done), 32'd0);
      chk({tag, "_dut_in"}, 32'(if4.dut_in), 32'd0);
      chk({tag, "_signature"}, 32'(if4.signature), 32'd0);
      chk({tag, "_match"}, 32'(if4.match), 32'd0);
      chk({tag, "_first_fail"}, 32'(if4.first_fail), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t;
      int unsigned d;
      bit seen;
      if4.start = 1'b0; if4.abort = 1'b0;
      if1.start = 1'b0; if1.abort = 1'b0;
      if2.start = 1'b0; if2.abort = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_u4_zero("reset");
      chk("reset_u1_busy", 32'(if1.busy), 32'd0);
      chk("reset_u2_signature", 32'(if2.signature), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Correct gate: vector hold pattern and busy window
      m4 = 0;
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      for (int j = 0; j < 32; j++) begin
         chk("sweep_dut_in", 32'(if4.dut_in), 32'(j / 4));
         chk("sweep_busy", 32'(if4.busy), 32'd1);
         @(negedge clk);
      end
      chk("busy_low_at_done", 32'(if4.busy), 32'd0);
      wait_empty(4, 10);
      repeat (3) @(negedge clk);
      chk("result_hold_signature", 32'(if4.signature), 32'hC2);
      chk("result_hold_match", 32'(if4.match), 32'd1);

      // Inverted gate
      m4 = 1;
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'h3D, match: 1'b0, ff: 3'd0});
      wait_empty(4, 60);
      repeat (2) @(negedge clk);

      // Row 5 stuck-at-1
      m4 = 2;
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'hC6, match: 1'b0, ff: 3'd5});
      wait_empty(4, 60);
      repeat (2) @(negedge clk);

      // Second start while busy is ignored
      m4 = 0;
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      repeat (9) @(negedge clk);
      if4.start = 1'b1;
      @(negedge clk);
      if4.start = 1'b0;
      wait_empty(4, 60);
      repeat (45) @(negedge clk);

      // Abort mid-sweep: no done, everything cleared
      kick(4, t);
      repeat (9) @(negedge clk);
      if4.abort = 1'b1;
      @(negedge clk);
      if4.abort = 1'b0;
      chk("abort_cycle", cyc, t + 11);
      chk_u4_zero("abort");
      repeat (40) @(negedge clk);
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      wait_empty(4, 60);
      repeat (2) @(negedge clk);

      // Reset mid-sweep
      m4 = 1;
      kick(4, t);
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_mid_cycle", cyc, t + 13);
      chk_u4_zero("reset_mid");
      repeat (40) @(negedge clk);
      m4 = 0;
      kick(4, t);
      q4.push_back('{cyc: t + 33, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      wait_empty(4, 60);

      // SETTLE=1 against a registered gate: each row sees the previous vector
      kick(1, t);
      q1.push_back('{cyc: t + 9, sig: 8'hE1, match: 1'b0, ff: 3'd2});
      wait_empty(1, 30);

      // SETTLE=2 against the same registered gate, then a back-to-back start
      kick(2, t);
      q2.push_back('{cyc: t + 17, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      seen = 1'b0;
      d = 0;
      for (int i = 0; i < 40; i++) begin
         if (if2.done === 1'b1) begin
            seen = 1'b1;
            d = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("u2_first_done_seen", 32'(seen), 32'd1);
      // Held across the done cycle (ignored there) and the following IDLE cycle.
      if2.start = 1'b1;
      @(negedge clk);
      q2.push_back('{cyc: d + 18, sig: 8'hC2, match: 1'b1, ff: 3'd0});
      @(negedge clk);
      if2.start = 1'b0;
      wait_empty(2, 40);
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of a 3-input combinational logic gate module (e.g. m0xC2) and drives its {in1, in2, in3} inputs.
- Steps through every input combination in ascending order, waits a programmable settle time per vector, samples the gate's `out`, and assembles an output signature.
- Compares the signature against an expected truth-table code and reports match/first-failing row.
- Used for on-chip characterisation of compiled logic circuits.

Parameters:
- N_IN, 3: number of gate inputs; sweep length is 2**N_IN vectors.
- SETTLE, 4: cycles each vector is held before `out` is sampled; legal range 1..255.
- EXPECT, 8'hC2: expected signature, width 2**N_IN. Row 0 (all inputs 0) maps to the MSB.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- abort  input  1  cancel a sweep in progress
- dut_in  output  N_IN  gate stimulus; dut_in[N_IN-1] drives in1, dut_in[0] drives in3
- dut_out  input  1  gate output (`out`)
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when a sweep completes
- signature  output  2**N_IN  captured truth table; row v lands in bit (2**N_IN-1-v)
- match  output  1  signature == EXPECT; valid from done until the next start
- first_fail  output  N_IN  lowest row index whose sample differs from EXPECT; 0 when match=1

Behaviour:
- Reset:
  - All outputs go to 0: dut_in, busy, done, signature, match, first_fail.
  - State returns to IDLE and the settle counter clears.
  - Reset takes priority over every other input in any state, including mid-sweep.
- FSM states: IDLE, APPLY, FINISH.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 moves to APPLY on the next cycle.
  - On that transition: signature, match and first_fail clear to 0; vector index v=0; count=0.
- APPLY:
  - busy=1, dut_in=v.
  - count increments each cycle.
  - On the cycle where count==SETTLE-1, dut_out is sampled directly, unregistered, into signature bit (2**N_IN-1-v).
  - After that sample, if v<2**N_IN-1: v increments and count resets to 0. The new vector appears on dut_in the next cycle.
  - If v==2**N_IN-1: go to FINISH.
  - Each vector is therefore held exactly SETTLE cycles.
- FINISH:
  - Lasts one cycle: done=1, busy=0.
  - match and first_fail are registered so they are valid in the same cycle as done.
  - Returns to IDLE; signature, match and first_fail hold until the next accepted start.
- Latency: start sampled at cycle t gives busy high for cycles t+1 .. t+2**N_IN*SETTLE, and done at cycle t+2**N_IN*SETTLE+1.
- First failure: first_fail is computed as a running value, latched at the first mismatching sample (lowest v). Later mismatches do not overwrite it.
- start handling:
  - start while busy or in FINISH is ignored (not queued).
  - start in the cycle after done (back in IDLE) is accepted normally.
- abort while busy:
  - Next cycle: IDLE, dut_in=0, busy=0.
  - No done pulse; signature, match and first_fail are cleared to 0.
  - abort in IDLE or FINISH has no effect.
  - abort and start together in IDLE: abort has no effect and start is accepted.
- Widths and wrap: count is 8 bits; v is N_IN bits and never wraps, because the sweep stops at the last row.
- dut_out is assumed synchronous to clk. Any combinational-gate or external settling delay is covered by SETTLE.

Test Plan:
- Correct gate, SETTLE=4: reset, then a combinational 0xC2 model on dut_in/dut_out, start at cycle 0 -> dut_in steps 0..7, each held 4 cycles; done at cycle 33; signature=8'hC2, match=1, first_fail=0.
- Inverted model (~0xC2): full sweep -> signature=8'h3D, match=0, first_fail=0.
- Row 5 stuck-at-1: model outputs 1 for row 5 -> signature=8'hC6, match=0, first_fail=5.
- start pulsed at cycles 0 and 10 -> exactly one done at cycle 33. abort at cycle 10 -> busy=0 and dut_in=0 at cycle 11, no done, signature=0. A following start completes normally.
- reset asserted mid-sweep at cycle 12 -> all outputs 0 at cycle 13, state IDLE; a later start produces a full 33-cycle sweep.
- SETTLE=1 with a model that has 1-cycle registered delay -> signature is shifted (mismatch). The same model with SETTLE=2 gives match=1. Back-to-back start in the cycle after done is accepted.
